// File: rtl/dmem_portb_arbiter_if.sv
// DMEM port B bus: CCD writer and accelerator requester sides plus the ram port B pins.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_portb_arbiter_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 256
);
   logic              ccd_req;
   logic              ccd_gnt;
   logic              ccd_wren;
   logic [ADDR_W-1:0] ccd_addr;
   logic [DATA_W-1:0] ccd_data;

   logic              acc_req;
   logic              acc_gnt;
   logic              acc_wren;
   logic              acc_rden;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [DATA_W-1:0] acc_rdata;
   logic              acc_rvalid;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              ram_wren;
   logic              ram_rden;
   logic [DATA_W-1:0] ram_q;

   logic              strobe_err;

   modport slave (
      input  ccd_req, ccd_wren, ccd_addr, ccd_data,
      input  acc_req, acc_wren, acc_rden, acc_addr, acc_wdata,
      input  ram_q,
      output ccd_gnt, acc_gnt, acc_rdata, acc_rvalid,
      output ram_addr, ram_data, ram_wren, ram_rden, strobe_err
   );

   modport master (
      output ccd_req, ccd_wren, ccd_addr, ccd_data,
      output acc_req, acc_wren, acc_rden, acc_addr, acc_wdata,
      output ram_q,
      input  ccd_gnt, acc_gnt, acc_rdata, acc_rvalid,
      input  ram_addr, ram_data, ram_wren, ram_rden, strobe_err
   );
endinterface

// File: rtl/dmem_portb_arbiter.sv
// DMEM port B arbiter: sticky per-burst grants between CCD writer and accelerator,
// round-robin tie break, burst cap, one idle TURN cycle between owners, tagged read return.
module dmem_portb_arbiter #(
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 256,
   parameter int MAX_BURST = 32,
   parameter int RD_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dmem_portb_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, GNT_CCD, GNT_ACC, TURN} state_t;

   typedef struct packed {
      logic              wren;
      logic              rden;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ram_cmd_t;

   state_t           state;
   logic             last_acc;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ccd_gnt_q, acc_gnt_q;
   logic             ccd_hon, acc_any, acc_hon, own_hon, at_cap;
   logic             pick_ccd, pick_acc, err_set, err_q;
   ram_cmd_t         cmd;
   logic [RD_LAT:1]  vld_pipe;

   assign ccd_hon  = ccd_gnt_q & bus.ccd_wren;
   assign acc_any  = bus.acc_wren | bus.acc_rden;
   assign acc_hon  = acc_gnt_q & acc_any;
   assign own_hon  = ccd_hon | acc_hon;
   assign cnt_nxt  = (burst_cnt == CNT_W'(MAX_BURST)) ? burst_cnt : burst_cnt + CNT_W'(own_hon);
   assign at_cap   = (cnt_nxt == CNT_W'(MAX_BURST));
   // Tie goes to whoever did not own the port last.
   assign pick_ccd = bus.ccd_req & (~bus.acc_req | last_acc);
   assign pick_acc = bus.acc_req & (~bus.ccd_req | ~last_acc);
   assign err_set  = (bus.ccd_wren & ~ccd_gnt_q) | (acc_any & ~acc_gnt_q) |
                     (bus.acc_wren & bus.acc_rden);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_acc  <= 1'b1;
         burst_cnt <= '0;
         ccd_gnt_q <= 1'b0;
         acc_gnt_q <= 1'b0;
      end else begin
         case (state)
            IDLE, TURN: begin
               burst_cnt <= '0;
               if (pick_ccd) begin
                  state     <= GNT_CCD;
                  ccd_gnt_q <= 1'b1;
               end else if (pick_acc) begin
                  state     <= GNT_ACC;
                  acc_gnt_q <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            GNT_CCD: begin
               if (!bus.ccd_req || (at_cap && bus.acc_req)) begin
                  state     <= TURN;
                  ccd_gnt_q <= 1'b0;
                  last_acc  <= 1'b0;
               end else begin
                  burst_cnt <= cnt_nxt;
               end
            end
            GNT_ACC: begin
               if (!bus.acc_req || (at_cap && bus.ccd_req)) begin
                  state     <= TURN;
                  acc_gnt_q <= 1'b0;
                  last_acc  <= 1'b1;
               end else begin
                  burst_cnt <= cnt_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Address/data hold their last value between accesses; strobes are single-cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd <= '0;
      end else begin
         cmd.wren <= ccd_hon | (acc_hon & bus.acc_wren);
         cmd.rden <= acc_hon & bus.acc_rden & ~bus.acc_wren;
         if (own_hon) begin
            cmd.addr <= ccd_gnt_q ? bus.ccd_addr : bus.acc_addr;
            cmd.data <= ccd_gnt_q ? bus.ccd_data : bus.acc_wdata;
         end
      end
   end

   // Read tag follows ram_rden; independent of grant so issued reads always complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         err_q    <= 1'b0;
      end else begin
         vld_pipe[1] <= cmd.rden;
         for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
         if (err_set) err_q <= 1'b1;
      end
   end

   assign bus.ccd_gnt    = ccd_gnt_q;
   assign bus.acc_gnt    = acc_gnt_q;
   assign bus.ram_wren   = cmd.wren;
   assign bus.ram_rden   = cmd.rden;
   assign bus.ram_addr   = cmd.addr;
   assign bus.ram_data   = cmd.data;
   assign bus.acc_rvalid = vld_pipe[RD_LAT];
   assign bus.acc_rdata  = vld_pipe[RD_LAT] ? bus.ram_q : '0;
   assign bus.strobe_err = err_q;
endmodule
